binary_mul_10_rr_arb: RTL and testbench

BINARY_MUL_10_RR_ARB -- requirements
Module: binary_mul_10_rr_arb

---
 rtl/binary_mul_10_rr_arb.sv | 108 ++++++++++
 tb/tb_binary_mul_10_rr_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_mul_10_rr_arb.sv
// Two-requester round-robin front end for a shared external 10x10 multiplier.
// Tags ride alongside the multiplier pipeline so each product is routed back to its issuer.
module binary_mul_10_rr_arb #(
    parameter int LATENCY = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    input  logic [9:0]  req_a_0,
    input  logic [9:0]  req_b_0,
    input  logic [9:0]  req_a_1,
    input  logic [9:0]  req_b_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    output logic [9:0]  mul_A,
    output logic [9:0]  mul_B,
    output logic        mul_en,
    input  logic [19:0] mul_P,
    output logic        res_valid_0,
    output logic        res_valid_1,
    output logic [19:0] res_p,
    output logic [3:0]  inflight,
    output logic        idle
);

    logic               r_last;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_id;
    logic               r_res_vld_0;
    logic               r_res_vld_1;
    logic [3:0]         r_inflight;
    logic [9:0]         r_mul_a;
    logic [9:0]         r_mul_b;
    logic               r_mul_en;

    logic               w_gnt_0;
    logic               w_gnt_1;
    logic               w_xfer;
    logic               w_retire;

    // rst_n is an active-high reset despite its name; no grant while it is held.
    always_comb begin
        w_gnt_0  = ~pause & ~rst_n & req_valid_0 & (~req_valid_1 | r_last);
        w_gnt_1  = ~pause & ~rst_n & req_valid_1 & (~req_valid_0 | ~r_last);
        w_xfer   = w_gnt_0 | w_gnt_1;
        w_retire = r_tag_vld[LATENCY-1];
    end

    // Issue stage: operand registers and arbitration pointer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_last   <= 1'b1;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_mul_en <= 1'b0;
        end else begin
            r_mul_en <= 1'b1;
            if (w_xfer) begin
                r_last  <= w_gnt_1;
                r_mul_a <= w_gnt_1 ? req_a_1 : req_a_0;
                r_mul_b <= w_gnt_1 ? req_b_1 : req_b_0;
            end
        end
    end

    // Tag pipeline; the result flags are registered off the last stage so they line up
    // with the product appearing LATENCY cycles after the operands.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_tag_vld   <= '0;
            r_tag_id    <= '0;
            r_res_vld_0 <= 1'b0;
            r_res_vld_1 <= 1'b0;
        end else begin
            r_tag_vld   <= {r_tag_vld[LATENCY-2:0], w_xfer};
            r_tag_id    <= {r_tag_id[LATENCY-2:0], w_gnt_1};
            r_res_vld_0 <= r_tag_vld[LATENCY-1] & ~r_tag_id[LATENCY-1];
            r_res_vld_1 <= r_tag_vld[LATENCY-1] &  r_tag_id[LATENCY-1];
        end
    end

    // An op is retired on the edge its result flag rises, which caps the count at LATENCY.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, w_retire})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign req_ready_0 = w_gnt_0;
    assign req_ready_1 = w_gnt_1;
    assign mul_A       = r_mul_a;
    assign mul_B       = r_mul_b;
    assign mul_en      = r_mul_en;
    assign res_valid_0 = r_res_vld_0;
    assign res_valid_1 = r_res_vld_1;
    assign res_p       = mul_P;
    assign inflight    = r_inflight;
    assign idle        = (r_inflight == 4'd0) & ~w_xfer;

endmodule

// File: tb/tb_binary_mul_10_rr_arb.sv
// Directed bench for binary_mul_10_rr_arb with a behavioural 11-cycle multiplier
// and a cycle model of grants, result routing and in-flight count.
module tb_binary_mul_10_rr_arb;

    localparam int L = 11;

    logic        clk;
    logic        rst_n;
    logic        pause;
    logic        req_valid_0, req_valid_1;
    logic [9:0]  req_a_0, req_b_0, req_a_1, req_b_1;
    logic        req_ready_0, req_ready_1;
    logic [9:0]  mul_A, mul_B;
    logic        mul_en;
    logic [19:0] mul_P;
    logic        res_valid_0, res_valid_1;
    logic [19:0] res_p;
    logic [3:0]  inflight;
    logic        idle;

    int n_tot = 0;
    int n_bad = 0;

    logic        m_v  [0:L];
    logic        m_id [0:L];
    logic [19:0] m_p  [0:L];
    int          m_inf;
    logic        m_last;
    int          obs_gid;

    logic [19:0] pipe [0:L-1];

    binary_mul_10_rr_arb #(.LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .mul_A(mul_A), .mul_B(mul_B), .mul_en(mul_en), .mul_P(mul_P),
        .res_valid_0(res_valid_0), .res_valid_1(res_valid_1), .res_p(res_p),
        .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: product of the operands held after edge k appears after edge k+L.
    always @(posedge clk) begin
        pipe[0] <= {10'd0, mul_A} * {10'd0, mul_B};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_P = pipe[L-1];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i <= L; i++) begin
            m_v[i] = 1'b0; m_id[i] = 1'b0; m_p[i] = '0;
        end
        m_inf  = 0;
        m_last = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1; pause = 1'b0; req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        chk("rst_rdy0", int'(req_ready_0), 0);
        chk("rst_rdy1", int'(req_ready_1), 0);
        chk("rst_rv0", int'(res_valid_0), 0);
        chk("rst_rv1", int'(res_valid_1), 0);
        chk("rst_mulA", int'(mul_A), 0);
        chk("rst_mulB", int'(mul_B), 0);
        chk("rst_en", int'(mul_en), 0);
        chk("rst_inf", int'(inflight), 0);
        chk("rst_idle", int'(idle), 1);
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rel_en", int'(mul_en), 0);
    endtask

    // One clock: check grants before the edge, advance the model, check outputs after it.
    task automatic cyc();
        logic g0, g1;
        logic [19:0] p;
        #1;
        g0 = !pause && req_valid_0 && (!req_valid_1 || m_last);
        g1 = !pause && req_valid_1 && (!req_valid_0 || !m_last);
        p  = g1 ? {10'd0, req_a_1} * {10'd0, req_b_1} : {10'd0, req_a_0} * {10'd0, req_b_0};
        chk("rdy0", int'(req_ready_0), int'(g0));
        chk("rdy1", int'(req_ready_1), int'(g1));
        chk("idle", int'(idle), int'(m_inf == 0 && !g0 && !g1));
        obs_gid = req_ready_1 ? 1 : (req_ready_0 ? 0 : 2);
        @(posedge clk);
        for (int i = L; i > 0; i--) begin
            m_v[i] = m_v[i-1]; m_id[i] = m_id[i-1]; m_p[i] = m_p[i-1];
        end
        m_v[0] = g0 | g1; m_id[0] = g1; m_p[0] = p;
        m_inf  = m_inf + int'(g0 | g1) - int'(m_v[L]);
        if (g0 | g1) m_last = g1;
        @(negedge clk);
        chk("rv0", int'(res_valid_0), int'(m_v[L] && !m_id[L]));
        chk("rv1", int'(res_valid_1), int'(m_v[L] && m_id[L]));
        if (m_v[L]) chk("resp", int'(res_p), int'(m_p[L]));
        chk("inf", int'(inflight), m_inf);
        chk("en", int'(mul_en), 1);
        if (g0 | g1) begin
            chk("mulA", int'(mul_A), int'(g1 ? req_a_1 : req_a_0));
            chk("mulB", int'(mul_B), int'(g1 ? req_b_1 : req_b_0));
        end
    endtask

    initial begin
        int n, cnt;
        int got_p [0:2];
        int got_id[0:2];
        rst_n = 1'b1; pause = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;
        model_clear();

        // Single request at maximum operands.
        do_reset();
        req_valid_0 = 1'b1; req_a_0 = 10'd1023; req_b_0 = 10'd1023;
        cyc();
        chk("single_gnt", obs_gid, 0);
        req_valid_0 = 1'b0;
        n = 0;
        while (!res_valid_0 && n < 20) begin cyc(); n++; end
        chk("single_lat", n, 11);
        chk("single_p", int'(res_p), 1046529);
        chk("single_inf", int'(inflight), 0);
        for (int i = 0; i < 3; i++) cyc();

        // Continuous contention.
        do_reset();
        req_valid_0 = 1'b1; req_a_0 = 10'd3; req_b_0 = 10'd5;
        req_valid_1 = 1'b1; req_a_1 = 10'd7; req_b_1 = 10'd9;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (i < 4) chk("alt_gnt", obs_gid, i % 2);
            if (i >= 10) chk("sat_inf", int'(inflight), 11);
            if (i >= 11) begin
                chk("alt_res", int'(res_p), ((i - 11) % 2 != 0) ? 63 : 15);
                chk("alt_id", int'(res_valid_1), (i - 11) % 2);
            end
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        for (int i = 0; i < 14; i++) cyc();

        // Pause with operations in flight.
        do_reset();
        req_valid_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a_0 = 10'(10 + i); req_b_0 = 10'(20 + i);
            cyc();
        end
        pause = 1'b1; req_valid_1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (res_valid_0) cnt++;
        end
        chk("pause_res", cnt, 4);
        chk("pause_idle", int'(idle), 1);
        pause = 1'b0;
        #1;
        chk("resume_rdy1", int'(req_ready_1), 1);
        cyc();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        for (int i = 0; i < 14; i++) cyc();

        // Reset while five operations are in flight.
        do_reset();
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        do_reset();
        chk("rst_inf_after", int'(inflight), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (res_valid_0 || res_valid_1) cnt++;
        end
        chk("rst_drop", cnt, 0);
        req_valid_0 = 1'b1; req_a_0 = 10'd2; req_b_0 = 10'd2;
        cyc();
        req_valid_0 = 1'b0;
        n = 0;
        while (!res_valid_0 && n < 20) begin cyc(); n++; end
        chk("post_rst_lat", n, 11);
        chk("post_rst_p", int'(res_p), 4);
        for (int i = 0; i < 3; i++) cyc();

        // Operand boundaries, alternating requesters.
        do_reset();
        req_valid_0 = 1'b1; req_a_0 = 10'd0; req_b_0 = 10'd1023;
        cyc();
        req_valid_0 = 1'b0; req_valid_1 = 1'b1; req_a_1 = 10'd1023; req_b_1 = 10'd0;
        cyc();
        req_valid_1 = 1'b0; req_valid_0 = 1'b1; req_a_0 = 10'd1; req_b_0 = 10'd1;
        cyc();
        req_valid_0 = 1'b0;
        for (int k = 0; k < 3; k++) begin got_p[k] = -1; got_id[k] = -1; end
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if ((res_valid_0 || res_valid_1) && cnt < 3) begin
                got_p[cnt]  = int'(res_p);
                got_id[cnt] = int'(res_valid_1);
                cnt++;
            end
        end
        chk("bnd_p0", got_p[0], 0);
        chk("bnd_id0", got_id[0], 0);
        chk("bnd_p1", got_p[1], 0);
        chk("bnd_id1", got_id[1], 1);
        chk("bnd_p2", got_p[2], 1);
        chk("bnd_id2", got_id[2], 0);

        // Random requests, gaps and pauses against the cycle model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_valid_0 = 1'(($urandom_range(0, 3) != 0) ? 1 : 0);
            req_valid_1 = 1'(($urandom_range(0, 3) != 0) ? 1 : 0);
            pause       = 1'(($urandom_range(0, 9) == 0) ? 1 : 0);
            req_a_0 = 10'($urandom_range(0, 1023)); req_b_0 = 10'($urandom_range(0, 1023));
            req_a_1 = 10'($urandom_range(0, 1023)); req_b_1 = 10'($urandom_range(0, 1023));
            cyc();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0; pause = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        chk("final_idle", int'(idle), 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
